// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous memory port between instruction fetch and data access.
// Data normally wins; a starvation counter forces a waiting fetch through after STARVE_LIMIT denials.
module mem_port_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int READ_LAT     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]       starve_cnt;
  logic                force_i;
  logic                rd_issue;
  logic [READ_LAT-1:0] tag_v;
  logic [READ_LAT-1:0] tag_d;

  // Grants are gated by rst so nothing reaches the memory while reset is held.
  always_comb begin
    force_i   = i_req && (starve_cnt == LIMIT);
    d_gnt     = !rst && d_req && !force_i;
    i_gnt     = !rst && i_req && (!d_req || force_i);
    mem_addr  = d_gnt ? d_addr : i_addr;
    mem_wren  = d_gnt && d_we;
    mem_wdata = d_wdata;
    rd_issue  = i_gnt || (d_gnt && !d_we);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (i_req && !i_gnt) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Tag pipeline mirrors the memory read latency; tag_d marks data-port ownership.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      tag_d <= '0;
    end else begin
      tag_v[0] <= rd_issue;
      tag_d[0] <= d_gnt;
      for (int k = 1; k < READ_LAT; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_d[k] <= tag_d[k-1];
      end
    end
  end

  assign i_rvalid = tag_v[READ_LAT-1] && !tag_d[READ_LAT-1];
  assign d_rvalid = tag_v[READ_LAT-1] &&  tag_d[READ_LAT-1];
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one synchronous memory port (the CPU-side port of the dual-port instruction/data RAM) between two requesters: instruction fetch (read-only) and data access (LDR/STR, read/write).
- Grants at most one access per cycle.
- Tracks in-flight reads through a latency pipeline and routes each returned word back to its issuer.
- Data accesses normally win; a starvation guard guarantees fetch forward progress.

Parameters:
ADDR_W, 11, memory word-address width
DATA_W, 32, memory data width
READ_LAT, 2, memory read latency in cycles from address edge to valid mem_rdata; legal values 1 or 2
STARVE_LIMIT, 4, consecutive cycles a pending fetch may be denied before it is forced through; legal range >= 1

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
i_req  in  1  fetch request; held with i_addr stable until i_gnt
i_addr  in  ADDR_W  fetch word address
i_gnt  out  1  fetch accepted this cycle
i_rvalid  out  1  fetch read data valid
i_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data access accepted this cycle
d_rvalid  out  1  data read data valid (reads only)
d_rdata  out  DATA_W  data read data
mem_addr  out  ADDR_W  memory address
mem_wren  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, READ_LAT cycles after address

Behaviour:
- Grant logic (combinational, same cycle as request):
  - d_req wins over i_req, except when starve_cnt == STARVE_LIMIT and i_req = 1; then fetch wins.
  - Exactly one of i_gnt/d_gnt is high when any request is pending; neither when none is pending.
  - The request is consumed on the clk edge that ends the grant cycle.
- Memory drive:
  - mem_addr = winner's address; mem_wdata = d_wdata.
  - mem_wren = d_gnt & d_we.
  - With no grant: mem_wren = 0; mem_addr = i_addr (don't care).
- Starvation counter starve_cnt, width clog2(STARVE_LIMIT+1):
  - Increments on each edge where i_req = 1 and i_gnt = 0, saturating at STARVE_LIMIT.
  - Clears on an edge with i_gnt = 1 or i_req = 0.
- Read-return pipeline:
  - READ_LAT-deep shift register of {valid, owner} tags.
  - A granted read (fetch, or data with d_we = 0) enters valid = 1 with owner I or D; a write or no grant enters valid = 0.
  - Tag at depth READ_LAT: i_rvalid = valid & owner I; d_rvalid = valid & owner D.
  - i_rdata = d_rdata = mem_rdata (unqualified; consumers use rvalid).
  - Fully pipelined: one read per cycle, returns in issue order, exactly READ_LAT cycles after the grant edge.
- Writes produce no rvalid. Write granted in cycle N is visible to a read granted in cycle N+1.
- Reset (rst high, asynchronous):
  - i_gnt, d_gnt, mem_wren forced 0 combinationally while rst = 1.
  - Tag pipeline cleared, so i_rvalid = d_rvalid = 0; starve_cnt = 0.
  - In-flight reads at reset assertion are discarded and never produce rvalid.
  - First grant possible in the first cycle after rst deasserts.
- Simultaneous events:
  - A grant cycle that also retires an older read is legal; both happen.
  - Requester dropping req without a grant is a protocol violation; the block does not record the request.

Test Plan:
1. Assert rst with i_req = d_req = 1 and a read in flight → i_gnt = d_gnt = mem_wren = 0, no rvalid ever appears for the in-flight read, starve_cnt = 0; after release, d_gnt on the first cycle.
2. Lone fetch of addr 5 holding 0xE0800000 (READ_LAT = 2) → i_gnt same cycle, mem_addr = 5; i_rvalid high exactly 2 edges later for one cycle with i_rdata = 0xE0800000; d_rvalid stays 0.
3. Simultaneous fetch addr 0 and data read addr 29 → d_gnt in cycle N, i_gnt in N+1; d_rvalid at N+2 and i_rvalid at N+3, each with correct word.
4. d_req held continuously with new addresses every grant, i_req held, STARVE_LIMIT = 4 → i_gnt on the 5th cycle of waiting; d_gnt = 0 that cycle only, then data resumes.
5. Data write of 8 to addr 29 (d_we = 1), then data read of addr 29 → mem_wren = 1 for one cycle, no rvalid for the write; read returns 8.
6. Alternating back-to-back reads across both ports for 16 cycles, at READ_LAT = 1 and READ_LAT = 2 → one grant per cycle, every rvalid routed to its issuer in order, no lost or duplicated returns.
